// File: rtl/stop_watch_ctrl_if.sv
// Signal bundle between the stopwatch button controller and its surroundings.
// The slave side is the controller; the master side drives buttons and live digits.
interface stop_watch_ctrl_if;
  logic       btn_ss_i;
  logic       btn_clr_i;
  logic       btn_lap_i;
  logic [3:0] d2_i;
  logic [3:0] d1_i;
  logic [3:0] d0_i;
  logic       go_o;
  logic       clr_o;
  logic [3:0] d2_o;
  logic [3:0] d1_o;
  logic [3:0] d0_o;
  logic       blank_o;
  logic       lap_o;
  logic [1:0] state_o;

  modport slave (
    input  btn_ss_i, btn_clr_i, btn_lap_i, d2_i, d1_i, d0_i,
    output go_o, clr_o, d2_o, d1_o, d0_o, blank_o, lap_o, state_o
  );

  modport master (
    output btn_ss_i, btn_clr_i, btn_lap_i, d2_i, d1_i, d0_i,
    input  go_o, clr_o, d2_o, d1_o, d0_o, blank_o, lap_o, state_o
  );
endinterface

// File: rtl/stop_watch_ctrl.sv
// Stopwatch button controller: debounced buttons, CLEARED/RUN/PAUSED FSM, pause blink.
// Define STOP_WATCH_CTRL_LAP_HOLD_EN to add the lap button and frozen-digit hold.
module stop_watch_ctrl #(
  parameter int DB_CYCLES    = 2_000_000,
  parameter int BLINK_CYCLES = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  stop_watch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_BAD     = 2'b11
  } state_e;

`ifdef STOP_WATCH_CTRL_LAP_HOLD_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;
  localparam int BTN_LAP = 2;

  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int BKW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_CYCLES - 1);

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] press;

  assign btn_raw[BTN_SS]  = bus.btn_ss_i;
  assign btn_raw[BTN_CLR] = bus.btn_clr_i;
`ifdef STOP_WATCH_CTRL_LAP_HOLD_EN
  assign btn_raw[BTN_LAP] = bus.btn_lap_i;
`endif

  // One synchroniser + debouncer per button; any disagreement shorter than
  // DB_CYCLES restarts the count because cnt clears whenever s2 matches db.
  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      logic           s1_q;
      logic           s2_q;
      logic           db_q;
      logic           db_prev_q;
      logic [DBW-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          db_q      <= 1'b0;
          db_prev_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          s1_q      <= btn_raw[gi];
          s2_q      <= s1_q;
          db_prev_q <= db_q;
          if (s2_q == db_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            db_q  <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + DBW'(1);
          end
        end
      end

      assign press[gi] = db_q & ~db_prev_q;
    end
  endgenerate

  state_e         state_q, state_d;
  logic           go_q;
  logic           clr_q, clr_d;
  logic           blank_q, blank_d;
  logic [BKW-1:0] blink_q, blink_d;

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    blink_d = '0;
    blank_d = 1'b0;

    case (state_q)
      ST_CLEARED: begin
        if (press[BTN_CLR]) begin
          clr_d = 1'b1;
        end else if (press[BTN_SS]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (press[BTN_SS]) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (press[BTN_CLR]) begin
          state_d = ST_CLEARED;
          clr_d   = 1'b1;
        end else if (press[BTN_SS]) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_CLEARED;
      end
    endcase

    // Blink only runs while staying in PAUSED; entry restarts it dark=0.
    if ((state_q == ST_PAUSED) && (state_d == ST_PAUSED)) begin
      if (blink_q == BK_LAST) begin
        blink_d = '0;
        blank_d = ~blank_q;
      end else begin
        blink_d = blink_q + BKW'(1);
        blank_d = blank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEARED;
      go_q    <= 1'b0;
      clr_q   <= 1'b1;
      blank_q <= 1'b0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= (state_d == ST_RUN);
      clr_q   <= clr_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
    end
  end

  assign bus.go_o    = go_q;
  assign bus.clr_o   = clr_q;
  assign bus.blank_o = blank_q;
  assign bus.state_o = state_q;

`ifdef STOP_WATCH_CTRL_LAP_HOLD_EN
  logic        lap_q, lap_d;
  logic [11:0] hold_q, hold_d;

  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if ((state_q == ST_RUN) && press[BTN_LAP]) begin
      if (!lap_q) begin
        lap_d  = 1'b1;
        hold_d = {bus.d2_i, bus.d1_i, bus.d0_i};
      end else begin
        lap_d = 1'b0;
      end
    end
    if (state_d == ST_CLEARED) begin
      lap_d  = 1'b0;
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end

  assign bus.lap_o = lap_q;
  assign bus.d2_o  = lap_q ? hold_q[11:8] : bus.d2_i;
  assign bus.d1_o  = lap_q ? hold_q[7:4]  : bus.d1_i;
  assign bus.d0_o  = lap_q ? hold_q[3:0]  : bus.d0_i;
`else
  logic unused_lap;
  assign unused_lap = bus.btn_lap_i;

  assign bus.lap_o = 1'b0;
  assign bus.d2_o  = bus.d2_i;
  assign bus.d1_o  = bus.d1_i;
  assign bus.d0_o  = bus.d0_i;
`endif

endmodule
